// File: rtl/slot_mem_responder_pkg.sv
// Shared types for the slot memory responder: FSM state encoding and the idle data-bus value.
// No logic of its own; imported by the responder and its sub-modules.
package slot_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RAM_REQ  = 3'd1,
      ST_RAM_WAIT = 3'd2,
      ST_SRAM_RD  = 3'd3,
      ST_SRAM_CAP = 3'd4,
      ST_DONE     = 3'd5
   } mem_resp_state_t;

   localparam logic [7:0] DATA_IDLE = 8'hFF;

   // States in which the CPU must be held in wait.
   function automatic logic is_busy(input mem_resp_state_t s);
      return (s == ST_RAM_REQ) || (s == ST_RAM_WAIT) || (s == ST_SRAM_RD) || (s == ST_SRAM_CAP);
   endfunction

endpackage

// File: rtl/slot_mem_responder_if.sv
// Mapper-side request, CPU wait/data return and both backing-store ports of one slot expander.
// slave = the responder, master = CPU/mapper/memory side.
interface slot_mem_responder_if #(
   parameter int ADDR_W  = 27,
   parameter int SRAM_AW = 18
);
   logic               cpu_mreq;
   logic               cpu_rd;
   logic               cpu_wr;
   logic [7:0]         cpu_dout;
   logic [ADDR_W-1:0]  mem_addr;
   logic               mem_rnw;
   logic               mem_ram_cs;
   logic               mem_sram_cs;
   logic               cpu_wait;
   logic [7:0]         data;
   logic               ram_req;
   logic               ram_we;
   logic [ADDR_W-1:0]  ram_addr;
   logic [7:0]         ram_din;
   logic               ram_ack;
   logic [7:0]         ram_dout;
   logic [SRAM_AW-1:0] sram_addr;
   logic               sram_we;
   logic [7:0]         sram_din;
   logic [7:0]         sram_dout;
   logic               timeout_err;

   modport slave (
      input  cpu_mreq, cpu_rd, cpu_wr, cpu_dout, mem_addr, mem_rnw, mem_ram_cs, mem_sram_cs,
      input  ram_ack, ram_dout, sram_dout,
      output cpu_wait, data, ram_req, ram_we, ram_addr, ram_din, sram_addr, sram_we, sram_din,
      output timeout_err
   );

   modport master (
      output cpu_mreq, cpu_rd, cpu_wr, cpu_dout, mem_addr, mem_rnw, mem_ram_cs, mem_sram_cs,
      output ram_ack, ram_dout, sram_dout,
      input  cpu_wait, data, ram_req, ram_we, ram_addr, ram_din, sram_addr, sram_we, sram_din,
      input  timeout_err
   );

endinterface

// File: rtl/slot_mem_responder_timeout_ctr.sv
// Ack-wait watchdog: counts enabled cycles after a clear, expired when the count equals LIMIT.
// Expired is combinational from the count; the counter holds once expired.
module mem_timeout_ctr #(
   parameter int W     = 8,
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + 1'b1;
   end

   assign expired = (cnt == LIM);

endmodule

// File: rtl/slot_mem_responder.sv
// Executes mapper bus accesses on SDRAM (req/ack) or SRAM (BRAM, 2-cycle read); data FF when idle.
// Latency: SRAM read 2 cycles after start, SDRAM until ram_ack or timeout; CPU held via cpu_wait meanwhile.
module slot_mem_responder
   import slot_mem_pkg::*;
#(
   parameter int ADDR_W  = 27,
   parameter int SRAM_AW = 18,
   parameter int TIMEOUT = 255
) (
   input logic                 clk,
   input logic                 reset_n,
   slot_mem_responder_if.slave bus
);
   mem_resp_state_t    state;
   logic               strobe;
   logic               strobe_q;
   logic               start;
   logic               is_write;
   logic               wait_start;
   logic               rd_q;
   logic [7:0]         data_q;
   logic               ram_req_q;
   logic               ram_we_q;
   logic [ADDR_W-1:0]  ram_addr_q;
   logic [7:0]         ram_din_q;
   logic [SRAM_AW-1:0] sram_addr_q;
   logic [7:0]         sram_din_q;
   logic               sram_we_q;
   logic               timeout_q;
   logic               expired;

   assign strobe   = bus.cpu_mreq & (bus.cpu_rd | bus.cpu_wr);
   assign start    = strobe & ~strobe_q & (state == ST_IDLE);
   assign is_write = ~bus.cpu_rd;

   // Wait must be visible in the request cycle itself, before the FSM has moved.
   assign wait_start = start & (bus.mem_sram_cs ? bus.cpu_rd
                                                : (bus.mem_ram_cs & ~(is_write & bus.mem_rnw)));

   mem_timeout_ctr #(
      .W     (8),
      .LIMIT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (state == ST_RAM_REQ),
      .en      (state == ST_RAM_WAIT),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         strobe_q    <= 1'b0;
         rd_q        <= 1'b0;
         data_q      <= DATA_IDLE;
         ram_req_q   <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
         sram_we_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         strobe_q  <= strobe;
         ram_req_q <= 1'b0;
         ram_we_q  <= 1'b0;
         sram_we_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rd_q <= bus.cpu_rd;
                  if (bus.mem_sram_cs) begin
                     sram_addr_q <= bus.mem_addr[SRAM_AW-1:0];
                     if (bus.cpu_rd) begin
                        state <= ST_SRAM_RD;
                     end else begin
                        if (!bus.mem_rnw) begin
                           sram_we_q  <= 1'b1;
                           sram_din_q <= bus.cpu_dout;
                        end
                        state <= ST_DONE;
                     end
                  end else if (bus.mem_ram_cs) begin
                     // SDRAM address/data only load here, so they stay put until the ack.
                     if (is_write && bus.mem_rnw) begin
                        state <= ST_DONE;
                     end else begin
                        ram_addr_q <= bus.mem_addr;
                        ram_din_q  <= bus.cpu_dout;
                        ram_req_q  <= 1'b1;
                        ram_we_q   <= is_write;
                        state      <= ST_RAM_REQ;
                     end
                  end
               end
            end
            ST_RAM_REQ, ST_RAM_WAIT: begin
               if (bus.ram_ack) begin
                  if (rd_q)
                     data_q <= bus.ram_dout;
                  state <= ST_DONE;
               end else if ((state == ST_RAM_WAIT) && expired) begin
                  data_q    <= DATA_IDLE;
                  timeout_q <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  state <= ST_RAM_WAIT;
               end
            end
            ST_SRAM_RD: state <= ST_SRAM_CAP;
            ST_SRAM_CAP: begin
               data_q <= bus.sram_dout;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               if (!strobe) begin
                  data_q <= DATA_IDLE;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cpu_wait    = wait_start | is_busy(state);
   assign bus.data        = data_q;
   assign bus.ram_req     = ram_req_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_din     = ram_din_q;
   assign bus.sram_addr   = sram_addr_q;
   assign bus.sram_we     = sram_we_q;
   assign bus.sram_din    = sram_din_q;
   assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_slot_mem_responder.sv
// Bench for slot_mem_responder: vector table of single accesses plus hand-written multi-cycle sequences,
// with SDRAM (programmable ack delay) and BRAM models and a data scoreboard.
module tb_slot_mem_responder;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   slot_mem_responder_if #(.ADDR_W(27), .SRAM_AW(18)) bus ();

   slot_mem_responder #(.ADDR_W(27), .SRAM_AW(18), .TIMEOUT(255)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      string      name;
      bit         rd;
      bit         ram_cs;
      bit         sram_cs;
      bit         rnw;
      logic [26:0] addr;
      logic [7:0] wdat;
      int         ack_dly;
      logic [7:0] rdat;
      int         exp_wait;
      int         exp_req;
      int         exp_swe;
      logic [7:0] exp_data;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   // SDRAM model state
   int          req_cnt = 0, ack_cnt = 0, swe_cnt = 0, stab_err = 0;
   int          ram_delay = 0, ack_left = 0;
   bit          ack_pending = 0, ram_mute = 0, chk_stable = 1;
   logic [7:0]  ram_rd_val = 8'h00;
   logic [26:0] req_addr = '0;
   logic        req_we = 1'b0;
   logic [7:0]  req_din = 8'h00;
   logic [7:0]  swe_din = 8'h00;
   logic [17:0] swe_addr = '0;
   logic [7:0]  last_wr_dat = 8'h00;
   logic [7:0]  sram_mem[int];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      bus.ram_ack  = 1'b0;
      bus.ram_dout = 8'hEE;
      if (ack_pending && chk_stable && (bus.ram_addr !== req_addr || bus.ram_din !== req_din))
         stab_err++;
      if (ack_pending) begin
         ack_left--;
         if (ack_left == 0) begin
            bus.ram_ack  = 1'b1;
            bus.ram_dout = ram_rd_val;
            ack_pending  = 0;
            ack_cnt++;
         end
      end
      if (bus.ram_req === 1'b1) begin
         req_cnt++;
         req_addr = bus.ram_addr;
         req_we   = bus.ram_we;
         req_din  = bus.ram_din;
         if (!ram_mute) begin
            if (ram_delay == 0) begin
               bus.ram_ack  = 1'b1;
               bus.ram_dout = ram_rd_val;
               ack_cnt++;
            end else begin
               ack_pending = 1;
               ack_left    = ram_delay;
            end
         end
      end
      if (bus.sram_we === 1'b1) begin
         swe_cnt++;
         swe_din  = bus.sram_din;
         swe_addr = bus.sram_addr;
      end
   end

   // BRAM model: read data one clock after the address
   always @(posedge clk) begin
      if (bus.sram_we === 1'b1)
         sram_mem[int'(bus.sram_addr)] = bus.sram_din;
      bus.sram_dout <= sram_mem.exists(int'(bus.sram_addr)) ? sram_mem[int'(bus.sram_addr)] : 8'h00;
   end

   task automatic drive_req(input bit rd, input bit ram_cs, input bit sram_cs, input bit rnw,
                            input logic [26:0] addr, input logic [7:0] wdat);
      bus.mem_addr    = addr;
      bus.mem_rnw     = rnw;
      bus.mem_ram_cs  = ram_cs;
      bus.mem_sram_cs = sram_cs;
      bus.cpu_dout    = wdat;
      bus.cpu_rd      = rd;
      bus.cpu_wr      = !rd;
      bus.cpu_mreq    = 1'b1;
   endtask

   task automatic drop_req();
      bus.cpu_mreq = 1'b0;
      bus.cpu_rd   = 1'b0;
      bus.cpu_wr   = 1'b0;
   endtask

   // Counts further wait cycles until cpu_wait falls, bounded.
   task automatic wait_release(input string name, inout int n);
      bit done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (!bus.cpu_wait) done = 1;
         else n++;
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s.release: cpu_wait still high after 400 cycles, required low", name);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int wn, req0, swe0;
      logic [7:0] expd;
      req0 = req_cnt;
      swe0 = swe_cnt;
      ram_delay  = v.ack_dly;
      ram_rd_val = v.rdat;
      @(negedge clk);
      drive_req(v.rd, v.ram_cs, v.sram_cs, v.rnw, v.addr, v.wdat);
      exp_q.push_back(v.exp_data);
      #1 wn = bus.cpu_wait ? 1 : 0;
      wait_release(v.name, wn);
      check({v.name, ".wait_cycles"}, wn, v.exp_wait);
      expd = exp_q.pop_front();
      check({v.name, ".data"}, bus.data, expd);
      @(negedge clk);
      check({v.name, ".data_hold"}, bus.data, v.exp_data);
      drop_req();
      @(negedge clk);
      check({v.name, ".data_idle"}, bus.data, 8'hFF);
      @(negedge clk);
      check({v.name, ".ram_req_cycles"}, req_cnt - req0, v.exp_req);
      check({v.name, ".sram_we_cycles"}, swe_cnt - swe0, v.exp_swe);
      if (v.exp_req == 1) begin
         check({v.name, ".ram_addr"}, req_addr, v.addr);
         check({v.name, ".ram_we"}, req_we, !v.rd);
         if (!v.rd) begin
            check({v.name, ".ram_din"}, req_din, v.wdat);
            last_wr_dat = v.wdat;
         end
      end
      if (v.exp_swe == 1) begin
         check({v.name, ".sram_din"}, swe_din, v.wdat);
         check({v.name, ".sram_addr"}, swe_addr, v.addr[17:0]);
      end
      if (v.ram_cs && !v.sram_cs && !v.rd && v.rnw)
         check({v.name, ".ram_din_unchanged"}, bus.ram_din, last_wr_dat);
   endtask

   vec_t vecs[13];

   initial begin
      int wn, req0, ack0, bad;
      logic [7:0] expd;

      vecs[0]  = '{"sdram_rd",       1, 1, 0, 0, 27'h0012345, 8'h00, 6, 8'h5A, 8, 1, 0, 8'h5A};
      vecs[1]  = '{"wr_ro_discard",  0, 1, 0, 1, 27'h0012345, 8'hA5, 2, 8'h00, 0, 0, 0, 8'hFF};
      vecs[2]  = '{"sdram_wr",       0, 1, 0, 0, 27'h00ABCDE, 8'h77, 3, 8'h00, 5, 1, 0, 8'hFF};
      vecs[3]  = '{"sdram_rd_ack0",  1, 1, 0, 0, 27'h4000001, 8'h00, 0, 8'hC3, 2, 1, 0, 8'hC3};
      vecs[4]  = '{"sram_wr",        0, 0, 1, 0, 27'h0001F00, 8'h3C, 0, 8'h00, 0, 0, 1, 8'hFF};
      vecs[5]  = '{"sram_rd",        1, 0, 1, 0, 27'h0001F00, 8'h00, 0, 8'h00, 3, 0, 0, 8'h3C};
      vecs[6]  = '{"both_cs_rd",     1, 1, 1, 1, 27'h0001F00, 8'h00, 2, 8'h11, 3, 0, 0, 8'h3C};
      vecs[7]  = '{"unmapped_rd",    1, 0, 0, 0, 27'h0123456, 8'h00, 2, 8'h22, 0, 0, 0, 8'hFF};
      vecs[8]  = '{"sram_wr_ro",     0, 0, 1, 1, 27'h0001F00, 8'h99, 0, 8'h00, 0, 0, 0, 8'hFF};
      vecs[9]  = '{"sram_rd_again",  1, 0, 1, 0, 27'h0001F00, 8'h00, 0, 8'h00, 3, 0, 0, 8'h3C};
      vecs[10] = '{"sdram_rd_ro",    1, 1, 0, 1, 27'h7FFFFFF, 8'h00, 1, 8'h81, 3, 1, 0, 8'h81};
      vecs[11] = '{"sram_wr_trunc",  0, 0, 1, 0, 27'h7C0002A, 8'hB7, 0, 8'h00, 0, 0, 1, 8'hFF};
      vecs[12] = '{"sram_rd_trunc",  1, 0, 1, 0, 27'h000002A, 8'h00, 0, 8'h00, 3, 0, 0, 8'hB7};

      reset_n = 1'b0;
      drop_req();
      bus.mem_addr = '0; bus.mem_rnw = 1'b0; bus.mem_ram_cs = 1'b0; bus.mem_sram_cs = 1'b0;
      bus.cpu_dout = 8'h00;
      repeat (2) @(negedge clk);
      check("reset.cpu_wait", bus.cpu_wait, 0);
      check("reset.data", bus.data, 8'hFF);
      check("reset.ram_req", bus.ram_req, 0);
      check("reset.ram_we", bus.ram_we, 0);
      check("reset.sram_we", bus.sram_we, 0);
      check("reset.timeout_err", bus.timeout_err, 0);
      check("reset.ram_addr", bus.ram_addr, 0);
      check("reset.ram_din", bus.ram_din, 0);
      check("reset.sram_addr", bus.sram_addr, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 13; i++) run_vec(vecs[i]);
      check("table.timeout_err_clear", bus.timeout_err, 0);

      // Strobe drops then returns mid-access: one access only, data held in DONE.
      req0 = req_cnt; ram_delay = 5; ram_rd_val = 8'h6E;
      @(negedge clk);
      drive_req(1, 1, 0, 0, 27'h0000033, 8'h00);
      exp_q.push_back(8'h6E);
      #1 wn = bus.cpu_wait ? 1 : 0;
      @(negedge clk); wn += bus.cpu_wait ? 1 : 0;
      @(negedge clk); wn += bus.cpu_wait ? 1 : 0; drop_req();
      @(negedge clk); wn += bus.cpu_wait ? 1 : 0; drive_req(1, 1, 0, 0, 27'h0000033, 8'h00);
      wait_release("rerise", wn);
      check("rerise.wait_cycles", wn, 7);
      expd = exp_q.pop_front();
      check("rerise.data", bus.data, expd);
      @(negedge clk);
      check("rerise.data_hold", bus.data, 8'h6E);
      drop_req();
      repeat (4) @(negedge clk);
      check("rerise.data_idle", bus.data, 8'hFF);
      check("rerise.ram_req_cycles", req_cnt - req0, 1);

      // Strobe drops and stays low: access completes, then straight back to idle.
      req0 = req_cnt; ram_delay = 3; ram_rd_val = 8'h4B;
      @(negedge clk);
      drive_req(1, 1, 0, 0, 27'h0000044, 8'h00);
      exp_q.push_back(8'h4B);
      #1 wn = bus.cpu_wait ? 1 : 0;
      @(negedge clk); wn += bus.cpu_wait ? 1 : 0; drop_req();
      wait_release("early_drop", wn);
      check("early_drop.wait_cycles", wn, 5);
      expd = exp_q.pop_front();
      check("early_drop.data", bus.data, expd);
      @(negedge clk);
      check("early_drop.data_idle", bus.data, 8'hFF);
      repeat (3) @(negedge clk);
      check("early_drop.ram_req_cycles", req_cnt - req0, 1);

      // Reset in the middle of RAM_WAIT; the late ack must be ignored.
      ram_delay = 10; ram_rd_val = 8'h44;
      @(negedge clk);
      drive_req(1, 1, 0, 0, 27'h0002222, 8'h00);
      repeat (4) @(negedge clk);
      chk_stable = 0;
      reset_n = 1'b0;
      drop_req();
      @(negedge clk);
      check("midreset.cpu_wait", bus.cpu_wait, 0);
      check("midreset.data", bus.data, 8'hFF);
      reset_n = 1'b1;
      req0 = req_cnt; ack0 = ack_cnt; bad = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.cpu_wait !== 1'b0 || bus.data !== 8'hFF) bad++;
      end
      check("midreset.stray_ack_seen", ack_cnt - ack0, 1);
      check("midreset.no_effect_cycles", bad, 0);
      check("midreset.ram_req_cycles", req_cnt - req0, 0);
      chk_stable = 1;

      // No ack at all: abort after the timeout, sticky error.
      ram_mute = 1;
      @(negedge clk);
      drive_req(1, 1, 0, 0, 27'h0000100, 8'h00);
      exp_q.push_back(8'hFF);
      #1 wn = bus.cpu_wait ? 1 : 0;
      wait_release("timeout", wn);
      check("timeout.wait_cycles", wn, 2 + 255 + 1);
      expd = exp_q.pop_front();
      check("timeout.data", bus.data, expd);
      check("timeout.err", bus.timeout_err, 1);
      drop_req();
      @(negedge clk);
      ram_mute = 0;
      run_vec(vecs[5]);
      run_vec(vecs[0]);
      check("timeout.err_sticky", bus.timeout_err, 1);

      check("scoreboard.empty", exp_q.size(), 0);
      check("ram_bus.stable_req_to_ack", stab_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at 100us, required to finish");
      $fatal(1, "watchdog expired");
   end

endmodule
